// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MDOperation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MDOperation, A, B,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, MDOperation, A, B,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Operands are latched as magnitudes; signs are applied once in the FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               isdiv;
    logic               negres;
    logic               negrem;
    logic               divzero;
    logic [WIDTH-1:0]   origa;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic               busyreg;
    logic               donereg;
    logic [WIDTH-1:0]   hireg;
    logic [WIDTH-1:0]   loreg;

    logic               signedop;
    logic [WIDTH-1:0]   absa;
    logic [WIDTH-1:0]   absb;
    logic [WIDTH:0]     addsum;
    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prodfix;
    logic [WIDTH-1:0]   quofix;
    logic [WIDTH-1:0]   remfix;

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        signedop = (bus.MDOperation == OP_MULT) || (bus.MDOperation == OP_DIV);
        absa     = (signedop && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        absb     = (signedop && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        addsum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        fits     = shifted >= {1'b0, opb};
        diff     = shifted[WIDTH-1:0] - opb;
        prodfix  = negres ? -acc : acc;
        quofix   = negres ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remfix   = negrem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            isdiv   <= 1'b0;
            negres  <= 1'b0;
            negrem  <= 1'b0;
            divzero <= 1'b0;
            origa   <= '0;
            opb     <= '0;
            acc     <= '0;
            busyreg <= 1'b0;
            donereg <= 1'b0;
            hireg   <= '0;
            loreg   <= '0;
        end else begin
            donereg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.MDOperation)
                            OP_MULT, OP_MULTU: begin
                                isdiv   <= 1'b0;
                                negres  <= signedop && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                                negrem  <= 1'b0;
                                divzero <= 1'b0;
                                origa   <= bus.A;
                                opb     <= absa;
                                acc     <= {{WIDTH{1'b0}}, absb};
                                count   <= '0;
                                busyreg <= 1'b1;
                                state   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                isdiv   <= 1'b1;
                                negres  <= signedop && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                                negrem  <= signedop && bus.A[WIDTH-1];
                                divzero <= (bus.B == '0);
                                origa   <= bus.A;
                                opb     <= absb;
                                acc     <= {{WIDTH{1'b0}}, absa};
                                count   <= '0;
                                busyreg <= 1'b1;
                                state   <= RUN;
                            end
                            OP_MTHI: hireg <= bus.A;
                            OP_MTLO: loreg <= bus.A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (isdiv) begin
                        if (fits)
                            acc <= {diff, acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        if (acc[0])
                            acc <= {addsum, acc[WIDTH-1:1]};
                        else
                            acc <= {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
                    end
                    if (count == LAST)
                        state <= FIX;
                end
                FIX: begin
                    // Divide by zero reports the raw dividend, bypassing sign correction.
                    if (isdiv) begin
                        if (divzero) begin
                            loreg <= '1;
                            hireg <= origa;
                        end else begin
                            loreg <= quofix;
                            hireg <= remfix;
                        end
                    end else begin
                        hireg <= prodfix[2*WIDTH-1:WIDTH];
                        loreg <= prodfix[WIDTH-1:0];
                    end
                    busyreg <= 1'b0;
                    donereg <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busyreg;
    assign bus.done = donereg;
    assign bus.HI   = hireg;
    assign bus.LO   = loreg;
endmodule
